// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX data-memory write-buffer unit: FSM encoding,
// default geometry and the buffered-store entry layout.
package dlx_mem_pkg;

  localparam int WBUF_DEPTH = 4;
  localparam int WBUF_AW    = 32;
  localparam int WBUF_DW    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_REQ  = 2'b01,
    WR_REQ  = 2'b10,
    RD_DONE = 2'b11
  } mem_state_t;

  typedef struct packed {
    logic [WBUF_AW-1:0] addr;
    logic [WBUF_DW-1:0] data;
  } wbuf_ent_t;

endpackage

// File: rtl/dlx_wbuf_fifo.sv
// Circular posted-store buffer with a parallel address-match network that
// returns the youngest matching entry for load forwarding.
module dlx_wbuf_fifo
  import dlx_mem_pkg::*;
#(
  parameter int  DEPTH = WBUF_DEPTH,
  parameter int  AW    = WBUF_AW,
  parameter int  DW    = WBUF_DW,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] lk_addr,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] match;

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slot validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {push_addr, push_data};
  end

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = mem_q[head_q].addr;
  assign head_data = mem_q[head_q].data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] age;
    assign age      = PW'(g) - head_q;
    assign match[g] = ({1'b0, age} < count_q) && (mem_q[g].addr == lk_addr);
  end

  assign hit = |match;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (match[idx]) hit_data = mem_q[idx].data;
    end
  end

endmodule

// File: rtl/dlx_dmem_wbuf.sv
// DLX data-memory interface: posted write buffer with load forwarding, and a
// single-outstanding req/ack bus shared by read misses and buffer drains.
module dlx_dmem_wbuf
  import dlx_mem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  parameter int AW    = WBUF_AW,
  parameter int DW    = WBUF_DW
) (
  input  logic          PHI1,
  input  logic          MRST,
  input  logic [AW-1:0] DAddr,
  input  logic          DRead,
  input  logic          DWrite,
  input  logic [DW-1:0] DOut,
  output logic [DW-1:0] DIn,
  output logic          Stall,
  output logic [AW-1:0] BAddr,
  output logic [DW-1:0] BWData,
  output logic          BWrite,
  output logic          BReq,
  input  logic          BAck,
  input  logic [DW-1:0] BRData
);

  mem_state_t    state_q, state_d;
  logic          breq_q, breq_d, bwrite_q, bwrite_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [DW-1:0] bwdata_q, bwdata_d, rd_data_q, rd_data_d;

  logic          rd, wr, rd_miss, rd_done, push, pop;
  logic          full, empty, hit;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data, hit_data;

  dlx_wbuf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (PHI1),
    .rst_n     (MRST),
    .push      (push),
    .push_addr (DAddr),
    .push_data (DOut),
    .pop       (pop),
    .lk_addr   (DAddr),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  always_comb begin
    rd      = DRead;
    wr      = DWrite & ~DRead;
    rd_miss = rd & ~hit;
    rd_done = (state_q == RD_DONE);
    // Full is the registered count, so a same-cycle pop still stalls once.
    push    = wr & ~full;
    Stall   = MRST & ((rd_miss & ~rd_done) | (wr & full));
    DIn     = (rd & hit & ~rd_done) ? hit_data : rd_data_q;

    state_d   = state_q;
    breq_d    = breq_q;
    bwrite_d  = bwrite_q;
    baddr_d   = baddr_q;
    bwdata_d  = bwdata_q;
    rd_data_d = rd_data_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d  = RD_REQ;
          breq_d   = 1'b1;
          bwrite_d = 1'b0;
          baddr_d  = DAddr;
        end else if (!empty) begin
          state_d  = WR_REQ;
          breq_d   = 1'b1;
          bwrite_d = 1'b1;
          baddr_d  = head_addr;
          bwdata_d = head_data;
        end
      end
      RD_REQ: begin
        // Entered from a drain with BReq low: issue after the mandatory idle cycle.
        if (!breq_q) begin
          breq_d   = 1'b1;
          bwrite_d = 1'b0;
          baddr_d  = DAddr;
        end else if (BAck) begin
          rd_data_d = BRData;
          breq_d    = 1'b0;
          state_d   = RD_DONE;
        end
      end
      WR_REQ: begin
        if (BAck) begin
          pop     = 1'b1;
          breq_d  = 1'b0;
          state_d = rd_miss ? RD_REQ : IDLE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PHI1 or negedge MRST) begin
    if (!MRST) begin
      state_q   <= IDLE;
      breq_q    <= 1'b0;
      bwrite_q  <= 1'b0;
      baddr_q   <= '0;
      bwdata_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      breq_q    <= breq_d;
      bwrite_q  <= bwrite_d;
      baddr_q   <= baddr_d;
      bwdata_q  <= bwdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign BReq   = breq_q;
  assign BWrite = bwrite_q;
  assign BAddr  = baddr_q;
  assign BWData = bwdata_q;

  a_rd_wr_excl: assert property (@(posedge PHI1) disable iff (!MRST) !(DRead && DWrite))
    else $error("dlx_dmem_wbuf: DRead and DWrite asserted together");

endmodule
